// File: rtl/fir_yout_quant.sv
// Output conditioning for the 4-tap FIR. Rounds the accumulator half-up by 2^SHIFT,
// saturates it to YOUT_W bits, buffers results in a fall-through FIFO and keeps clamp statistics.
module fir_yout_quant #(
    parameter int ACC_W  = 48,
    parameter int YOUT_W = 25,
    parameter int SHIFT  = 9,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ACC_W-1:0]  s_acc,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [YOUT_W-1:0] m_yout,
    input  logic              clr_stat,
    output logic              sat_flag,
    output logic [15:0]       sat_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = ACC_W + 1;

    localparam logic signed [RW-1:0] LIM_MAX = {{(RW-YOUT_W+1){1'b0}}, {(YOUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] LIM_MIN = {{(RW-YOUT_W+1){1'b1}}, {(YOUT_W-1){1'b0}}};
    localparam logic [YOUT_W-1:0]    Y_MAX   = {1'b0, {(YOUT_W-1){1'b1}}};
    localparam logic [YOUT_W-1:0]    Y_MIN   = {1'b1, {(YOUT_W-1){1'b0}}};
    localparam logic [AW-1:0]        PTR_ONE = AW'(1);
    localparam logic [AW:0]          CNT_ONE = (AW+1)'(1);
    localparam logic [AW+1:0]        OCC_LIM = (AW+2)'(DEPTH);

    logic signed [RW-1:0] w_sext;
    logic signed [RW-1:0] w_rnd;
    logic signed [RW-1:0] r_r1;
    logic                 r_v1;
    logic                 w_accept;

    logic                 w_over;
    logic                 w_under;
    logic                 w_sat_evt;
    logic [YOUT_W-1:0]    w_clamped;

    logic [YOUT_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_cnt;
    logic [AW+1:0]        w_occ;
    logic                 w_push;
    logic                 w_pop;

    logic                 r_sat_flag;
    logic [15:0]          r_sat_cnt;

    // Stage 1: one extra bit of headroom so adding the half-LSB never overflows.
    assign w_sext   = {s_acc[ACC_W-1], s_acc};
    assign w_accept = s_valid & s_ready;

    if (SHIFT == 0) begin : g_noshift
        assign w_rnd = w_sext;
    end else begin : g_shift
        localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
        logic signed [RW-1:0] w_sum;
        assign w_sum = w_sext + HALF;
        assign w_rnd = w_sum >>> SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_r1 <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_r1 <= w_rnd;
            end
        end
    end

    // Stage 2: clamp to the signed output range.
    assign w_over    = r_r1 > LIM_MAX;
    assign w_under   = r_r1 < LIM_MIN;
    assign w_sat_evt = r_v1 & (w_over | w_under);

    always_comb begin
        w_clamped = r_r1[YOUT_W-1:0];
        if (w_over) begin
            w_clamped = Y_MAX;
        end else if (w_under) begin
            w_clamped = Y_MIN;
        end
    end

    // The in-flight stage-1 sample reserves a slot, and same-edge pops give no credit,
    // so s_ready depends on registers only and the FIFO cannot overflow.
    assign w_push  = r_v1;
    assign m_valid = (r_cnt != '0);
    assign w_pop   = m_valid & m_ready;
    assign w_occ   = {1'b0, r_cnt} + (AW+2)'(r_v1);
    assign s_ready = w_occ < OCC_LIM;
    assign m_yout  = m_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_clamped;
        end
    end

    // A clear coinciding with a clamp keeps that clamp as the first counted event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_flag <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (clr_stat) begin
            r_sat_flag <= w_sat_evt;
            r_sat_cnt  <= w_sat_evt ? 16'd1 : 16'd0;
        end else if (w_sat_evt) begin
            r_sat_flag <= 1'b1;
            if (r_sat_cnt != 16'hFFFF) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign sat_flag = r_sat_flag;
    assign sat_cnt  = r_sat_cnt;

endmodule

// File: tb/tb_fir_yout_quant.sv
// Directed bench for fir_yout_quant: a queue-based reference model checked every cycle,
// plus literal expectations for rounding, saturation, back-pressure, stats and reset.
module tb_fir_yout_quant;

    localparam longint YMAX = (64'sd1 <<< 24) - 64'sd1;
    localparam longint YMIN = -(64'sd1 <<< 24);
    localparam longint P33  = 64'sd1 <<< 33;
    localparam longint P34  = 64'sd1 <<< 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_acc;
    logic        m_valid;
    logic        m_ready;
    logic [24:0] m_yout;
    logic        clr_stat;
    logic        sat_flag;
    logic [15:0] sat_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    fir_yout_quant #(.ACC_W(48), .YOUT_W(25), .SHIFT(9), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_acc    (s_acc),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_yout   (m_yout),
        .clr_stat (clr_stat),
        .sat_flag (sat_flag),
        .sat_cnt  (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: floor((a + 256) / 512), then clamp to the 25-bit signed range.
    function automatic longint quant(input longint a, output bit clamped);
        longint n;
        longint q;
        n = a + 64'sd256;
        q = n / 64'sd512;
        if (n < 0 && (n % 64'sd512) != 0) q = q - 1;
        clamped = 1'b1;
        if (q > YMAX) return YMAX;
        if (q < YMIN) return YMIN;
        clamped = 1'b0;
        return q;
    endfunction

    // Model state: pending stage-1 sample, FIFO contents, statistics.
    longint mq[$];
    bit     pv;
    longint pacc;
    bit     sflag;
    int     scnt;
    bit     a_pop, a_acc, a_clr;
    longint a_val;
    bit     exp_mv, exp_sr, m_evt;
    longint exp_y, m_y;
    int     cyc = 0;
    longint log_v[$];
    int     log_c[$];

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            pv = 0; sflag = 0; scnt = 0;
        end else begin
            if (a_pop && mq.size() != 0) void'(mq.pop_front());
            m_evt = 0;
            if (pv) begin
                m_y = quant(pacc, m_evt);
                mq.push_back(m_y);
            end
            if (a_clr) begin
                sflag = m_evt;
                scnt  = m_evt ? 1 : 0;
            end else if (m_evt) begin
                sflag = 1;
                if (scnt < 65535) scnt++;
            end
            pv   = a_acc;
            pacc = a_val;
        end
        cyc++;
        exp_mv = (mq.size() != 0);
        exp_y  = exp_mv ? mq[0] : 0;
        exp_sr = (mq.size() + (pv ? 1 : 0)) < 4;
        chk("m_valid", longint'(m_valid), longint'(exp_mv));
        chk("m_yout", $signed(m_yout), exp_y);
        chk("s_ready", longint'(s_ready), longint'(exp_sr));
        chk("sat_flag", longint'(sat_flag), longint'(sflag));
        chk("sat_cnt", longint'(sat_cnt), longint'(scnt));
        a_pop = exp_mv && m_ready && !rst;
        a_acc = s_valid && exp_sr && !rst;
        a_val = $signed(s_acc);
        a_clr = clr_stat && !rst;
        if (a_pop) begin
            log_v.push_back($signed(m_yout));
            log_c.push_back(cyc);
        end
    end

    task automatic drive(input logic v, input longint a, input logic mr, input logic clr);
        @(posedge clk);
        #2;
        s_valid  = v;
        s_acc    = a[47:0];
        m_ready  = mr;
        clr_stat = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic log_at(input string name, input int idx, input longint exp);
        chk(name, (idx < log_v.size()) ? log_v[idx] : -64'sd999999999, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int     acc_n;
        int     drops;
        longint a;

        rst = 1'b1; s_valid = 1'b0; s_acc = '0; m_ready = 1'b0; clr_stat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", longint'(m_valid), 0);
        chk("rst_s_ready", longint'(s_ready), 1);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_sat_cnt", longint'(sat_cnt), 0);
        #2 rst = 1'b0;

        // Rounding and first-sample latency.
        log_v.delete(); log_c.delete();
        drive(1'b1, 256, 1'b1, 1'b0);
        drive(1'b1, -256, 1'b1, 1'b0);
        chk("lat_edgeN_valid", longint'(m_valid), 0);
        drive(1'b1, 767, 1'b1, 1'b0);
        chk("lat_edgeN1_valid", longint'(m_valid), 1);
        chk("lat_edgeN1_yout", $signed(m_yout), 1);
        drive(1'b1, 768, 1'b1, 1'b0);
        drive(1'b1, -257, 1'b1, 1'b0);
        idle(4);
        chk("round_count", log_v.size(), 5);
        log_at("round_256", 0, 1);
        log_at("round_m256", 1, 0);
        log_at("round_767", 2, 1);
        log_at("round_768", 3, 2);
        log_at("round_m257", 4, -1);

        // Saturation at both rails.
        log_v.delete(); log_c.delete();
        drive(1'b1, P33, 1'b1, 1'b0);
        drive(1'b1, -P33, 1'b1, 1'b0);
        drive(1'b1, -P33 - 512, 1'b1, 1'b0);
        idle(4);
        log_at("sat_pos", 0, 16777215);
        log_at("sat_neg_exact", 1, -16777216);
        log_at("sat_neg_clamp", 2, -16777216);
        chk("sat_flag_after", longint'(sat_flag), 1);
        chk("sat_cnt_after", longint'(sat_cnt), 2);

        // Clear on the same edge as a clamp, then clear alone.
        drive(1'b1, P33, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(1);
        chk("clr_evt_flag", longint'(sat_flag), 1);
        chk("clr_evt_cnt", longint'(sat_cnt), 1);
        drive(1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(1);
        chk("clr_only_flag", longint'(sat_flag), 0);
        chk("clr_only_cnt", longint'(sat_cnt), 0);

        // Back-pressure: only DEPTH samples get in, then drain in order.
        log_v.delete(); log_c.delete();
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, longint'(i + 1) * 512, 1'b0, 1'b0);
            if (s_ready) acc_n++;
        end
        chk("bp_accepted", acc_n, 4);
        chk("bp_s_ready", longint'(s_ready), 0);
        chk("bp_hold_valid", longint'(m_valid), 1);
        chk("bp_hold_yout", $signed(m_yout), 1);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(6);
        chk("bp_drain_count", log_v.size(), 4);
        for (int i = 0; i < 4; i++) log_at("bp_drain_order", i, i + 1);

        // Streaming 100 back-to-back samples.
        log_v.delete(); log_c.delete();
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            a = longint'(i) * 104729 - 5000000 + longint'(i % 4) * 256;
            if (i % 10 == 3) a = P34;
            if (i % 10 == 7) a = -P34;
            drive(1'b1, a, 1'b1, 1'b0);
            if (!s_ready) drops++;
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(4);
        chk("stream_ready_drops", drops, 0);
        chk("stream_count", log_v.size(), 100);
        chk("stream_consecutive", (log_c.size() == 100) ? log_c[99] - log_c[0] : -1, 99);

        // Counter saturation at 16'hFFFF.
        drive(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++) drive(1'b1, P33, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(3);
        chk("cnt_hold_ffff", longint'(sat_cnt), 65535);
        chk("cnt_hold_flag", longint'(sat_flag), 1);

        // Asynchronous reset with 3 FIFO entries and a stage-1 sample in flight.
        log_v.delete(); log_c.delete();
        for (int i = 0; i < 4; i++) drive(1'b1, longint'(i + 1) * 1024, 1'b0, 1'b0);
        @(posedge clk);
        #2 s_valid = 1'b0;
        chk("pre_rst_valid", longint'(m_valid), 1);
        chk("pre_rst_s_ready", longint'(s_ready), 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_m_valid", longint'(m_valid), 0);
        chk("arst_s_ready", longint'(s_ready), 1);
        chk("arst_sat_flag", longint'(sat_flag), 0);
        chk("arst_sat_cnt", longint'(sat_cnt), 0);
        chk("arst_m_yout", $signed(m_yout), 0);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(5);
        chk("arst_no_stale", log_v.size(), 0);
        drive(1'b1, 7 * 512, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        idle(3);
        chk("arst_new_count", log_v.size(), 1);
        log_at("arst_new_value", 0, 7);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
